// File: rtl/quad_gen.sv
// Quadrature encoder emulator: walks a/b through Gray steps
// from the current position to a requested target.
module quad_gen #(
  parameter int WIDTH        = 8,
  parameter int PHASE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] target,
  input  logic             target_valid,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             a,
  output logic             b,
  output logic [WIDTH-1:0] position
);

  localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] DWELL_MAX = CW'(PHASE_CYCLES - 1);
  localparam logic [WIDTH-1:0] HALF = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  logic [CW-1:0]    dwell_q, dwell_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             zpend_q, zpend_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic [WIDTH-1:0] diff;
  logic             step_en;

  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    dwell_d = dwell_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    zpend_d = 1'b0;
    step_en = 1'b0;
    diff    = target - pos_q;
    unique case (state_q)
      IDLE: begin
        done_d = zpend_q;
        if (target_valid) begin
          if (diff == '0) begin
            zpend_d = 1'b1;
          end else begin
            state_d = RUN;
            dwell_d = DWELL_MAX;
            // the exact half-turn tie goes up
            if (diff[WIDTH-1] && diff != HALF) begin
              dir_d   = 1'b0;
              steps_d = WIDTH'(0) - diff;
            end else begin
              dir_d   = 1'b1;
              steps_d = diff;
            end
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          dwell_d = '0;
        end else if (dwell_q == '0) begin
          step_en = 1'b1;
          dwell_d = DWELL_MAX;
          steps_d = steps_q - WIDTH'(1);
          if (steps_q == WIDTH'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            dwell_d = '0;
          end
        end else begin
          dwell_d = dwell_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    pos_d = pos_q;
    if (step_en) begin
      pos_d = dir_q ? pos_q + WIDTH'(1) : pos_q - WIDTH'(1);
    end
    a_d = pos_d[1];
    b_d = pos_d[1] ^ pos_d[0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pos_q   <= '0;
      steps_q <= '0;
      dwell_q <= '0;
      dir_q   <= 1'b1;
      done_q  <= 1'b0;
      zpend_q <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      steps_q <= steps_d;
      dwell_q <= dwell_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      zpend_q <= zpend_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign a        = a_q;
  assign b        = b_q;
  assign position = pos_q;

endmodule

// File: tb/tb_quad_gen.sv
// Bench for quad_gen: directed moves, expected events queued,
// a negedge monitor pops and compares each step/done it sees.
module tb_quad_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] target = 8'h00;
  logic       target_valid = 1'b0;
  logic       abort = 1'b0;
  logic       ready, busy, done, a, b;
  logic [7:0] position;

  quad_gen #(.WIDTH(8), .PHASE_CYCLES(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .target(target),
    .target_valid(target_valid),
    .abort(abort),
    .ready(ready),
    .busy(busy),
    .done(done),
    .a(a),
    .b(b),
    .position(position)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    int         at;
    logic [7:0] pos;
    logic [1:0] ab;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         acc = 0;
  bit         mon_en = 1'b0;
  logic [7:0] prev_pos = 8'h00;
  logic [7:0] mpos = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] gray(input logic [7:0] p);
    return {p[1], p[1] ^ p[0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (cyc %0d)",
               nm, act, req, cyc);
    end
  endtask

  task automatic push_ev(input bit d, input int at,
                         input logic [7:0] p, input logic [1:0] ab);
    ev_t e;
    e.is_done = d;
    e.at      = at;
    e.pos     = p;
    e.ab      = ab;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input bit d);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL extra_event: got done=%0d pos=%h ab=%b cyc=%0d, required none",
               d, position, {a, b}, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done != d || e.at != cyc || e.pos !== position ||
          e.ab !== {a, b}) begin
        bad++;
        $display("FAIL event: got done=%0d pos=%h ab=%b cyc=%0d, required done=%0d pos=%h ab=%b cyc=%0d",
                 d, position, {a, b}, cyc, e.is_done, e.pos, e.ab, e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (position !== prev_pos) check_ev(1'b0);
      if (done !== 1'b0) begin
        check_ev(1'b1);
        chk("ready_with_done", {31'd0, ready}, 32'd1);
      end
      prev_pos = position;
    end
  end

  task automatic go_edge(input int e);
    do @(negedge clk); while (cyc < e - 1);
  endtask

  task automatic accept(input logic [7:0] t);
    @(negedge clk);
    target       = t;
    target_valid = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    target_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    if (mpos != 8'h00) push_ev(1'b0, cyc, 8'h00, 2'b00);
    mpos = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pos", {24'd0, position}, 32'd0);
    chk("rst_ab", {30'd0, a, b}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    prev_pos = 8'h00;
    mon_en   = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;

    // 0 -> 3, three up steps
    accept(8'h03);
    push_ev(1'b0, acc + 4, 8'h01, 2'b01);
    push_ev(1'b0, acc + 8, 8'h02, 2'b11);
    push_ev(1'b0, acc + 12, 8'h03, 2'b10);
    push_ev(1'b1, acc + 12, 8'h03, 2'b10);
    chk("a_busy", {31'd0, busy}, 32'd1);
    chk("a_ready", {31'd0, ready}, 32'd0);
    go_edge(acc + 16);
    mpos = 8'h03;
    chk("a_idle", {31'd0, ready}, 32'd1);

    // target equals position
    accept(8'h03);
    push_ev(1'b1, acc + 1, 8'h03, 2'b10);
    for (int i = 0; i < 5; i++) begin
      chk("z_busy", {31'd0, busy}, 32'd0);
      chk("z_pos", {24'd0, position}, 32'h03);
      @(negedge clk);
    end

    // 0 -> FE, two down steps through the wrap
    do_reset();
    accept(8'hFE);
    push_ev(1'b0, acc + 4, 8'hFF, 2'b10);
    push_ev(1'b0, acc + 8, 8'hFE, 2'b11);
    push_ev(1'b1, acc + 8, 8'hFE, 2'b11);
    go_edge(acc + 12);
    mpos = 8'hFE;

    // half-turn tie: 128 up steps
    do_reset();
    accept(8'h80);
    for (int k = 1; k <= 128; k++) begin
      push_ev(1'b0, acc + 4 * k, 8'(k), gray(8'(k)));
    end
    push_ev(1'b1, acc + 512, 8'h80, 2'b00);
    go_edge(acc + 200);
    chk("t_busy", {31'd0, busy}, 32'd1);
    go_edge(acc + 516);
    mpos = 8'h80;

    // abort at cycle 6, then move back to 0 with abort held
    do_reset();
    accept(8'h05);
    push_ev(1'b0, acc + 4, 8'h01, 2'b01);
    go_edge(acc + 6);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("ab_ready", {31'd0, ready}, 32'd1);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_pos", {24'd0, position}, 32'h01);
    chk("ab_ab", {30'd0, a, b}, 32'd1);
    @(negedge clk);
    abort = 1'b0;
    go_edge(acc + 14);
    abort = 1'b1;
    accept(8'h00);
    abort = 1'b0;
    push_ev(1'b0, acc + 4, 8'h00, 2'b00);
    push_ev(1'b1, acc + 4, 8'h00, 2'b00);
    go_edge(acc + 8);
    mpos = 8'h00;

    // reset mid-move, target_valid held during RUN
    accept(8'h0A);
    target       = 8'h40;
    target_valid = 1'b1;
    push_ev(1'b0, acc + 4, 8'h01, 2'b01);
    push_ev(1'b0, acc + 8, 8'h02, 2'b11);
    go_edge(acc + 9);
    reset_n      = 1'b0;
    target_valid = 1'b0;
    @(posedge clk);
    #1;
    push_ev(1'b0, cyc, 8'h00, 2'b00);
    chk("r_busy", {31'd0, busy}, 32'd0);
    chk("r_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    go_edge(acc + 24);
    chk("r_pos", {24'd0, position}, 32'd0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quad_gen.md
QUAD_GEN -- requirements
Module: quad_gen

Interface
REQ-001 Parameter WIDTH, default 8: width of position and target.
REQ-002 Parameter PHASE_CYCLES, default 16, legal range 2..65535: clocks each quadrature state is held before the next transition.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset_n  input  1  reset; synchronous and active-low.
REQ-005 target  input  WIDTH  requested position.
REQ-006 target_valid  input  1  target offered; accepted on a clk edge where target_valid and ready are both high.
REQ-007 abort  input  1  stop an in-progress move.
REQ-008 ready  output  1  high exactly when the FSM is in IDLE.
REQ-009 busy  output  1  high exactly when the FSM is in RUN.
REQ-010 done  output  1  one-cycle pulse when a move completes normally.
REQ-011 a  output  1  quadrature phase A, registered.
REQ-012 b  output  1  quadrature phase B, registered.
REQ-013 position  output  WIDTH  current emulated encoder count, registered.

Function
REQ-014 Purpose: emulate a rotary encoder by driving a/b through Gray steps until position equals the accepted target.
REQ-015 {a,b} SHALL always equal the Gray map of position[1:0]: 0->00, 1->01, 2->11, 3->10.
REQ-016 A step SHALL change position by exactly one and update {a,b} on the same edge.
REQ-017 Up step: position+1 mod 2^WIDTH. Down step: position-1 mod 2^WIDTH. Wrap FF->00 and 00->FF SHALL be legal steps.
REQ-018 FSM states: IDLE and RUN only.
REQ-019 On accept in IDLE, latch diff = (target - position) mod 2^WIDTH, interpreted as a signed value.
REQ-020 diff MSB clear: direction up, step count = diff.
REQ-021 diff MSB set: direction down, step count = 2^WIDTH - diff.
REQ-022 Tie case diff = 2^(WIDTH-1): direction up, step count 2^(WIDTH-1).
REQ-023 Accept with diff = 0: FSM stays in IDLE, done pulses on the next cycle, a/b/position unchanged.
REQ-024 Accept with diff != 0: enter RUN and load the dwell counter.
REQ-025 The first step SHALL occur PHASE_CYCLES clocks after the accept edge; each following step PHASE_CYCLES clocks after the previous one.
REQ-026 On the edge of the final step: return to IDLE and assert done for exactly one cycle.
REQ-027 ready SHALL be high in the cycle done is high.
REQ-028 target_valid in RUN SHALL be ignored; target is not re-sampled.
REQ-029 abort high in RUN: return to IDLE on that edge with no step on that edge; position and a/b hold; done stays low.
REQ-030 abort in IDLE SHALL be ignored; abort and target_valid together in IDLE -> the target is accepted.
REQ-031 abort on the same edge a step is due: abort wins, no step.
REQ-032 The dwell counter SHALL be sized ceil(log2(PHASE_CYCLES)) bits with no overflow.

Reset
REQ-033 reset_n low at a clk edge SHALL force IDLE, position=0, a=0, b=0, done=0, busy=0, ready=1, dwell counter=0, regardless of state.
REQ-034 Reset mid-move SHALL discard the move; no done pulse follows.

Verification (WIDTH=8, PHASE_CYCLES=4; cycle 0 = accept edge)
REQ-035 Reset, then target=3 -> ab=01/pos1 @4, ab=11/pos2 @8, ab=10/pos3 @12; done @12 only; ready high @12.
REQ-036 Position 0, target=0xFE -> ab=10/pos FF @4, ab=11/pos FE @8; done @8.
REQ-037 target equal to position -> done @1; a/b/position constant; busy never high.
REQ-038 Position 0, target=0x80 -> 128 up steps, pos 0x80 and done @512, ab=00.
REQ-039 target=5, abort at cycle 6 -> pos 1, ab 01 frozen; ready @6; no done; new target 0 then steps down to 0.
REQ-040 reset_n low at cycle 9 of a move to 10 -> next edge pos 0, ab 00, IDLE; no done; target_valid during RUN ignored throughout.
